div_seq_ctrl: RTL and testbench

Multi-cycle divide sequencer for the HI/LO path. It accepts a DIV/DIVU request from the EX stage and runs a 32-iteration restoring division. While the operation is in progress it drives the pipeline stall vector, and when finished it presents a 64-bit {remainder, quotient} result for the EX stage to write into HI/LO. It sits beside `ex` and feeds the pipeline hold logic that gates `pc_reg`, `if_id` and `id_ex`.

---
 rtl/div_seq_ctrl_if.sv | 23 ++
 rtl/div_seq_ctrl.sv | 101 ++++++++++
 tb/tb_div_seq_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_ctrl_if.sv
// Request/result bundle between the EX stage (master) and the divide sequencer (slave).
interface div_seq_ctrl_if #(
   parameter int DATA_W = 32
);
   logic                start;
   logic                signed_op;
   logic [DATA_W-1:0]   opdata1;
   logic [DATA_W-1:0]   opdata2;
   logic                annul;
   logic [2*DATA_W-1:0] result;
   logic                ready;
   logic [5:0]          stall;

   modport master (
      output start, signed_op, opdata1, opdata2, annul,
      input  result, ready, stall
   );

   modport slave (
      input  start, signed_op, opdata1, opdata2, annul,
      output result, ready, stall
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider for the HI/LO path; holds PC/IF/ID/EX while busy.
// state  | meaning
// IDLE   | waiting for a divide request
// BYZERO | divisor was zero, result forced to 0
// ON     | one restoring step per cycle, DATA_W steps
// DONE   | result valid, ready pulsed for one cycle
module div_seq_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic           clk,
   input  logic           rst,
   div_seq_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BYZERO, ON, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem, dvd, dsr;
   logic              neg_q, neg_r;
   logic              req;

   logic [DATA_W-1:0] mag_a, mag_b;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] diff, rem_nxt, quo_nxt;
   logic              q_bit;

   assign req = bus.start & ~bus.annul;

   // 0x80000000 negates to itself and is then used as an unsigned magnitude
   assign mag_a = (bus.signed_op & bus.opdata1[DATA_W-1]) ? -bus.opdata1 : bus.opdata1;
   assign mag_b = (bus.signed_op & bus.opdata2[DATA_W-1]) ? -bus.opdata2 : bus.opdata2;

   assign trial   = {rem, dvd[DATA_W-1]};
   assign q_bit   = (trial >= {1'b0, dsr});
   assign diff    = trial[DATA_W-1:0] - dsr;
   assign rem_nxt = q_bit ? diff : trial[DATA_W-1:0];
   assign quo_nxt = {dvd[DATA_W-2:0], q_bit};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (bus.opdata2 == '0) ? BYZERO : ON;
         BYZERO:  state_nxt = bus.annul ? IDLE : DONE;
         ON: begin
            if (bus.annul)       state_nxt = IDLE;
            else if (cnt == LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         rem        <= '0;
         dvd        <= '0;
         dsr        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         bus.result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req && bus.opdata2 != '0) begin
                  cnt   <= '0;
                  rem   <= '0;
                  dvd   <= mag_a;
                  dsr   <= mag_b;
                  neg_q <= bus.signed_op & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
                  neg_r <= bus.signed_op & bus.opdata1[DATA_W-1];
               end
            end
            BYZERO: if (!bus.annul) bus.result <= '0;
            ON: begin
               if (!bus.annul) begin
                  cnt <= cnt + 1'b1;
                  rem <= rem_nxt;
                  dvd <= quo_nxt;
                  if (cnt == LAST)
                     bus.result <= {neg_r ? -rem_nxt : rem_nxt,
                                    neg_q ? -quo_nxt : quo_nxt};
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ready = (state == DONE);
   assign bus.stall = (((state == IDLE) && req) ||
                       (((state == ON) || (state == BYZERO)) && !bus.annul)) ? 6'b001111 : 6'b000000;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench: table vectors, randomized divides against a magnitude/sign model, corner sequences.
module tb_div_seq_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_seq_ctrl_if #(.DATA_W(32)) bus ();
   div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ma, mb, q, r;
      if (b == 0) return 64'd0;
      ma = (s && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
      mb = (s && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
      q = ma / mb;
      r = ma % mb;
      if (s && (a[31] ^ b[31])) q = -q;
      if (s && a[31])           r = -r;
      return {r[31:0], q[31:0]};
   endfunction

   // Returns in the ready cycle (#1 after negedge); start is left high.
   task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int scnt, output logic [63:0] res);
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = s; bus.opdata1 = a; bus.opdata2 = b;
      lat = -1; scnt = 0; res = '0;
      for (int n = 0; n < 100; n++) begin
         #1;
         if (bus.stall == 6'h0F) scnt++;
         if (bus.ready) begin
            lat = n;
            res = bus.result;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic count_ready(input int cycles, output int pulses);
      pulses = 0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk); #1;
         if (bus.ready) pulses++;
      end
   endtask

   vec_t vecs[6];
   int lat, scnt, pulses;
   logic [63:0] res, res2, last_res;
   logic [31:0] ra, rb;
   bit rs;

   initial begin
      vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h00000002, 32'h0000000E}};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}};
      vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
      vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h00000000, 32'h80000000}};
      vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'h00000001, {32'h00000000, 32'hFFFFFFFF}};
      vecs[5] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h00000000}};

      rst = 1'b1;
      bus.start = 1'b0; bus.signed_op = 1'b0; bus.opdata1 = '0; bus.opdata2 = '0; bus.annul = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_result", bus.result, 64'd0);
      check("reset_ready",  {63'd0, bus.ready}, 64'd0);
      check("reset_stall",  {58'd0, bus.stall}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, scnt, res);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
         check($sformatf("vec%0d_stall_cycles", i), 64'(scnt), 64'd33);
         check($sformatf("vec%0d_stall_at_ready", i), {58'd0, bus.stall}, 64'd0);
         bus.start = 1'b0;
         @(negedge clk); #1;
         check($sformatf("vec%0d_ready_one_cycle", i), {63'd0, bus.ready}, 64'd0);
      end
      last_res = vecs[5].exp;

      // divide by zero
      run_div(1'b0, 32'h12345678, 32'd0, lat, scnt, res);
      bus.start = 1'b0;
      check("byzero_result", res, 64'd0);
      check("byzero_latency", 64'(lat), 64'd2);
      check("byzero_stall_cycles", 64'(scnt), 64'd2);
      last_res = 64'd0;

      // randomized against the reference model
      for (int i = 0; i < 20; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom_range(1, 15);
            1:       rb = -$urandom_range(1, 15);
            2:       rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            default: rb = $urandom;
         endcase
         run_div(rs, ra, rb, lat, scnt, res);
         bus.start = 1'b0;
         check($sformatf("rand%0d_%0d_%h_%h", i, rs, ra, rb), res, ref_div(rs, ra, rb));
         check($sformatf("rand%0d_latency", i), 64'(lat), (rb == 0) ? 64'd2 : 64'd33);
         last_res = res;
      end

      // annul at T+10
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
      repeat (10) @(negedge clk);
      bus.annul = 1'b1;
      #1;
      check("annul_stall_same_cycle", {58'd0, bus.stall}, 64'd0);
      @(negedge clk);
      bus.annul = 1'b0; bus.start = 1'b0;
      #1;
      check("annul_ready_after", {63'd0, bus.ready}, 64'd0);
      check("annul_stall_after", {58'd0, bus.stall}, 64'd0);
      check("annul_result_kept", bus.result, last_res);
      count_ready(40, pulses);
      check("annul_no_ready_pulse", 64'(pulses), 64'd0);
      check("annul_result_still_kept", bus.result, last_res);

      // rst at T+10
      @(negedge clk);
      bus.start = 1'b1; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0;
      #1;
      check("rst_mid_result", bus.result, 64'd0);
      check("rst_mid_ready", {63'd0, bus.ready}, 64'd0);
      check("rst_mid_stall", {58'd0, bus.stall}, 64'd0);
      count_ready(40, pulses);
      check("rst_mid_no_ready_pulse", 64'(pulses), 64'd0);

      // start with rst high is ignored
      @(negedge clk);
      rst = 1'b1; bus.start = 1'b1; bus.opdata1 = 32'd50; bus.opdata2 = 32'd5;
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0;
      count_ready(40, pulses);
      check("start_during_rst_ignored", 64'(pulses), 64'd0);

      // annul and start together in IDLE
      @(negedge clk);
      bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd50; bus.opdata2 = 32'd5;
      #1;
      check("annul_start_idle_stall", {58'd0, bus.stall}, 64'd0);
      @(negedge clk);
      bus.start = 1'b0; bus.annul = 1'b0;
      count_ready(40, pulses);
      check("annul_start_idle_no_start", 64'(pulses), 64'd0);
      check("annul_start_idle_result", bus.result, 64'd0);

      // back-to-back with start held
      run_div(1'b0, 32'd20, 32'd3, lat, scnt, res);
      run_div(1'b0, 32'd9, 32'd4, scnt, pulses, res2);
      bus.start = 1'b0;
      check("b2b_first_result", res, {32'd2, 32'd6});
      check("b2b_first_latency", 64'(lat), 64'd33);
      check("b2b_second_result", res2, {32'd1, 32'd2});
      check("b2b_second_latency", 64'(scnt), 64'd33);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
